// File: rtl/boss_hit_judge_mc_if.sv
// Boss hit-judge bundle: boss/bullet geometry in, hit/kill/health/state out.
interface boss_hit_judge_mc_if #(
    parameter int NB = 4,
    parameter int HW = 4
);
    logic [9:0]         boss_x;
    logic [9:0]         boss_y;
    logic [NB*10-1:0]   b_x;
    logic [NB*10-1:0]   b_y;
    logic [NB-1:0]      b_en;
    logic               boss_en;
    logic [HW-1:0]      max_health;
    logic [NB-1:0]      b_kill;
    logic               hit;
    logic [HW-1:0]      health;
    logic               boom;
    logic               revive;
    logic [2:0]         state;

    modport master (
        output boss_x, boss_y, b_x, b_y, b_en, boss_en, max_health,
        input  b_kill, hit, health, boom, revive, state
    );

    modport slave (
        input  boss_x, boss_y, b_x, b_y, b_en, boss_en, max_health,
        output b_kill, hit, health, boom, revive, state
    );
endinterface

// File: rtl/boss_hit_judge_mc.sv
// Boss collision judge: per-channel bullet hitbox test, damage, and
// IDLE/ALIVE/INVULN/DEAD/REVIVE lifecycle on one shared dwell timer.
module boss_hit_judge_mc #(
    parameter int NB       = 4,
    parameter int HW       = 4,
    parameter int BOX_L    = 10,
    parameter int BOX_R    = 50,
    parameter int BOX_T    = 40,
    parameter int BOX_B    = 50,
    parameter int Y_OFS    = 480,
    parameter int DMG_MODE = 0,
    parameter int INV_CYC  = 150000,
    parameter int DEAD_CYC = 67108864,
    parameter int REV_CYC  = 375000
) (
    input  logic                 clk,
    input  logic                 rst,
    boss_hit_judge_mc_if.slave   bus
);
    localparam int MAXC = (INV_CYC > DEAD_CYC)
                        ? ((INV_CYC > REV_CYC) ? INV_CYC : REV_CYC)
                        : ((DEAD_CYC > REV_CYC) ? DEAD_CYC : REV_CYC);
    localparam int TW = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIVE  = 3'd1,
        S_INVULN = 3'd2,
        S_DEAD   = 3'd3,
        S_REVIVE = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [HW-1:0]   health_q, health_d;
    logic [NB-1:0]   kill_q, kill_d;
    logic            hit_q, hit_d;
    logic [10:0]     ax_q, ax_d;
    logic [10:0]     ay_q, ay_d;
    logic [NB-1:0]   coll;
    logic [15:0]     dmg;
    logic [HW-1:0]   left;
    logic [HW-1:0]   eff_max;
    logic [15:0]     ax, ay, bx, by;

    assign eff_max = (bus.max_health == '0) ? HW'(1) : bus.max_health;
    assign ax_d    = {1'b0, bus.boss_x};
    assign ay_d    = 11'(bus.boss_y) + 11'(Y_OFS);
    assign ax      = 16'(ax_q);
    assign ay      = 16'(ay_q);

    // Bounds rearranged to additions so nothing can go negative; this also
    // gives the clamp-at-zero behaviour of the left edge for free.
    always_comb begin
        coll = '0;
        bx   = '0;
        by   = '0;
        for (int i = 0; i < NB; i++) begin
            bx = 16'(bus.b_x[10*i +: 10]);
            by = 16'(bus.b_y[10*i +: 10]);
            coll[i] = bus.b_en[i]
                    && (bx + 16'(BOX_L) >= ax)
                    && (bx < ax + 16'(BOX_R))
                    && (by + 16'(BOX_T) > ay)
                    && (by < ay + 16'(BOX_B));
        end
    end

    always_comb begin
        dmg = '0;
        if (DMG_MODE != 0) begin
            for (int i = 0; i < NB; i++) begin
                dmg = dmg + 16'(coll[i]);
            end
        end else begin
            dmg = 16'd1;
        end
        left = (16'(health_q) > dmg) ? HW'(16'(health_q) - dmg) : '0;
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + TW'(1);
        health_d = health_q;
        kill_d   = '0;
        hit_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                health_d = eff_max;
                timer_d  = '0;
                state_d  = S_ALIVE;
            end
            S_ALIVE: begin
                timer_d = '0;
                if (|coll) begin
                    kill_d   = coll;
                    hit_d    = 1'b1;
                    health_d = left;
                    state_d  = (left == '0) ? S_DEAD : S_INVULN;
                end
            end
            S_INVULN: begin
                if (timer_q == TW'(INV_CYC - 1)) begin
                    state_d = S_ALIVE;
                    timer_d = '0;
                end
            end
            S_DEAD: begin
                if (timer_q == TW'(DEAD_CYC - 1)) begin
                    state_d  = S_REVIVE;
                    timer_d  = '0;
                    health_d = eff_max;
                end
            end
            S_REVIVE: begin
                if (timer_q == TW'(REV_CYC - 1)) begin
                    state_d = S_ALIVE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
        // Despawn wins over anything else happening this cycle.
        if (!bus.boss_en) begin
            state_d  = S_IDLE;
            timer_d  = '0;
            health_d = eff_max;
            kill_d   = '0;
            hit_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            health_q <= eff_max;
            kill_q   <= '0;
            hit_q    <= 1'b0;
            ax_q     <= '0;
            ay_q     <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            health_q <= health_d;
            kill_q   <= kill_d;
            hit_q    <= hit_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
        end
    end

    assign bus.b_kill = kill_q;
    assign bus.hit    = hit_q;
    assign bus.health = health_q;
    assign bus.boom   = (state_q == S_DEAD);
    assign bus.revive = (state_q == S_REVIVE);
    assign bus.state  = state_q;
endmodule

// File: tb/tb_boss_hit_judge_mc.sv
// Bench for boss_hit_judge_mc: two instances (single and popcount damage)
// driven in lockstep and checked against a cycle-level behavioural model.
module tb_boss_hit_judge_mc;
    localparam int INV_C  = 5;
    localparam int DEAD_C = 7;
    localparam int REV_C  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  boss_x, boss_y;
    logic [39:0] bx_v, by_v;
    logic [3:0]  b_en;
    logic        boss_en;
    logic [3:0]  maxh;

    int n_cmp = 0;
    int n_bad = 0;

    int         m_st[2], m_hp[2], m_rem[2], m_ax[2], m_ay[2];
    logic [3:0] m_kill[2];
    logic       m_hit[2];

    always #5 clk = ~clk;

    boss_hit_judge_mc_if #(.NB(4), .HW(4)) if0 ();
    boss_hit_judge_mc_if #(.NB(4), .HW(4)) if1 ();

    assign if0.boss_x = boss_x;     assign if1.boss_x = boss_x;
    assign if0.boss_y = boss_y;     assign if1.boss_y = boss_y;
    assign if0.b_x = bx_v;          assign if1.b_x = bx_v;
    assign if0.b_y = by_v;          assign if1.b_y = by_v;
    assign if0.b_en = b_en;         assign if1.b_en = b_en;
    assign if0.boss_en = boss_en;   assign if1.boss_en = boss_en;
    assign if0.max_health = maxh;   assign if1.max_health = maxh;

    boss_hit_judge_mc #(
        .NB(4), .HW(4), .DMG_MODE(0),
        .INV_CYC(INV_C), .DEAD_CYC(DEAD_C), .REV_CYC(REV_C)
    ) dut0 (.clk(clk), .rst(rst), .bus(if0));

    boss_hit_judge_mc #(
        .NB(4), .HW(4), .DMG_MODE(1),
        .INV_CYC(INV_C), .DEAD_CYC(DEAD_C), .REV_CYC(REV_C)
    ) dut1 (.clk(clk), .rst(rst), .bus(if1));

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s t=%0t: got %0h expected %0h",
                         nm, $time, act, exp);
        end
    endtask

    function automatic int effm(int m);
        return (m == 0) ? 1 : m;
    endfunction

    // Model: anchor lags inputs by one edge; timed states count down
    // remaining cycles from their dwell length.
    task automatic model_step(int k);
        int lo, bx, by, dmg;
        logic [3:0] coll;
        if (!rst) begin
            m_st[k] = 0; m_hp[k] = effm(int'(maxh)); m_rem[k] = 0;
            m_kill[k] = '0; m_hit[k] = 1'b0; m_ax[k] = 0; m_ay[k] = 0;
            return;
        end
        lo = m_ax[k] - 10;
        if (lo < 0) lo = 0;
        coll = '0;
        for (int i = 0; i < 4; i++) begin
            bx = int'(bx_v[10*i +: 10]);
            by = int'(by_v[10*i +: 10]);
            coll[i] = b_en[i] && bx >= lo && bx < m_ax[k] + 50
                      && by > m_ay[k] - 40 && by < m_ay[k] + 50;
        end
        m_kill[k] = '0;
        m_hit[k]  = 1'b0;
        if (!boss_en) begin
            m_st[k] = 0; m_hp[k] = effm(int'(maxh)); m_rem[k] = 0;
        end else begin
            case (m_st[k])
                0: begin m_hp[k] = effm(int'(maxh)); m_st[k] = 1; end
                1: if (coll != 0) begin
                    dmg = (k == 1) ? $countones(coll) : 1;
                    m_kill[k] = coll;
                    m_hit[k]  = 1'b1;
                    m_hp[k]   = (m_hp[k] > dmg) ? m_hp[k] - dmg : 0;
                    if (m_hp[k] == 0) begin m_st[k] = 3; m_rem[k] = DEAD_C; end
                    else begin m_st[k] = 2; m_rem[k] = INV_C; end
                end
                2: begin m_rem[k]--; if (m_rem[k] == 0) m_st[k] = 1; end
                3: begin
                    m_rem[k]--;
                    if (m_rem[k] == 0) begin
                        m_st[k] = 4; m_rem[k] = REV_C; m_hp[k] = effm(int'(maxh));
                    end
                end
                4: begin m_rem[k]--; if (m_rem[k] == 0) m_st[k] = 1; end
                default: m_st[k] = 0;
            endcase
        end
        m_ax[k] = int'(boss_x);
        m_ay[k] = int'(boss_y) + 480;
    endtask

    task automatic check_dut(int k, logic [13:0] act);
        logic [13:0] exp;
        exp = {m_kill[k], m_hit[k], 4'(m_hp[k]), m_st[k] == 3,
               m_st[k] == 4, 3'(m_st[k])};
        chk($sformatf("model_dut%0d{kill,hit,hp,boom,rev,st}", k),
            32'(act), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_dut(0, {if0.b_kill, if0.hit, if0.health, if0.boom,
                      if0.revive, if0.state});
        check_dut(1, {if1.b_kill, if1.hit, if1.health, if1.boom,
                      if1.revive, if1.state});
    endtask

    task automatic set_bullet(int ch, int x, int y);
        bx_v[10*ch +: 10] = 10'(x);
        by_v[10*ch +: 10] = 10'(y);
    endtask

    // Reset, spawn at (px,py), and settle into ALIVE with anchor loaded.
    task automatic spawn(int px, int py, int mh);
        rst = 1'b0; boss_en = 1'b0; b_en = '0; maxh = 4'(mh);
        boss_x = 10'(px); boss_y = 10'(py);
        step();
        rst = 1'b1; boss_en = 1'b1;
        step();
        step();
    endtask

    typedef struct {
        int  px;
        int  bx;
        int  by;
        bit  exp;
    } vec_t;

    vec_t tbl[11];
    int   n;

    initial begin
        rst = 1'b0; boss_x = '0; boss_y = '0; bx_v = '0; by_v = '0;
        b_en = '0; boss_en = 1'b0; maxh = 4'd3;

        // Boss at (100,0): anchor (100,480), box x in [90,150), y in (440,530)
        tbl[0]  = '{100,  90, 480, 1'b1};
        tbl[1]  = '{100,  89, 480, 1'b0};
        tbl[2]  = '{100, 150, 480, 1'b0};
        tbl[3]  = '{100, 149, 480, 1'b1};
        tbl[4]  = '{100, 100, 440, 1'b0};
        tbl[5]  = '{100, 100, 441, 1'b1};
        tbl[6]  = '{100, 100, 530, 1'b0};
        tbl[7]  = '{100, 100, 529, 1'b1};
        tbl[8]  = '{  5,   0, 480, 1'b1};
        tbl[9]  = '{  5,  54, 480, 1'b1};
        tbl[10] = '{  5,  55, 480, 1'b0};

        step();
        chk("reset_state", 32'(if0.state), 32'd0);
        chk("reset_health", 32'(if0.health), 32'd3);
        chk("reset_boom", 32'(if0.boom), 32'd0);

        foreach (tbl[i]) begin
            spawn(tbl[i].px, 0, 3);
            set_bullet(0, tbl[i].bx, tbl[i].by);
            b_en = 4'b0001;
            step();
            chk($sformatf("edge_vec%0d_kill", i), 32'(if0.b_kill[0]),
                32'(tbl[i].exp));
            b_en = '0;
        end

        // Single bullet on channel 2, then exact invulnerable dwell
        spawn(100, 0, 3);
        set_bullet(2, 110, 480);
        b_en = 4'b0100;
        step();
        b_en = '0;
        chk("ch2_kill", 32'(if0.b_kill), 32'b0100);
        chk("ch2_hit", 32'(if0.hit), 32'd1);
        chk("ch2_health", 32'(if0.health), 32'd2);
        chk("ch2_state", 32'(if0.state), 32'd2);
        n = 1;
        for (int c = 0; c < 50; c++) begin
            step();
            if (if0.state != 3'd2) break;
            n++;
        end
        chk("invuln_len", 32'(n), 32'(INV_C));
        chk("invuln_exit", 32'(if0.state), 32'd1);

        // Three channels at once with popcount damage, then full death cycle
        spawn(100, 0, 2);
        set_bullet(0, 100, 480);
        set_bullet(1, 120, 500);
        set_bullet(3, 90, 441);
        b_en = 4'b1011;
        step();
        b_en = '0;
        chk("multi_kill", 32'(if1.b_kill), 32'b1011);
        chk("multi_health", 32'(if1.health), 32'd0);
        chk("multi_state", 32'(if1.state), 32'd3);
        chk("multi_boom", 32'(if1.boom), 32'd1);
        chk("multi_hit_once", 32'(if0.health), 32'd1);
        n = 1;
        for (int c = 0; c < 100; c++) begin
            step();
            if (!if1.boom) break;
            n++;
        end
        chk("boom_len", 32'(n), 32'(DEAD_C));
        chk("revive_health", 32'(if1.health), 32'd2);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            if (!if1.revive) break;
            n++;
            step();
        end
        chk("revive_len", 32'(n), 32'(REV_C));
        chk("revive_exit", 32'(if1.state), 32'd1);

        // Despawn during INVULN with a bullet overlapping
        spawn(100, 0, 3);
        set_bullet(0, 100, 480);
        b_en = 4'b0001;
        step();
        step();
        boss_en = 1'b0;
        step();
        chk("despawn_state", 32'(if0.state), 32'd0);
        chk("despawn_kill", 32'(if0.b_kill), 32'd0);
        b_en = '0;

        // Reset mid-DEAD, and zero max health treated as one
        spawn(100, 0, 0);
        chk("maxh0_health", 32'(if0.health), 32'd1);
        b_en = 4'b0001;
        step();
        b_en = '0;
        step();
        step();
        chk("dead_boom", 32'(if0.boom), 32'd1);
        rst = 1'b0;
        step();
        chk("rst_dead_boom", 32'(if0.boom), 32'd0);
        chk("rst_dead_state", 32'(if0.state), 32'd0);
        rst = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            int x, y;
            rst = ($urandom_range(0, 199) != 0);
            boss_en = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 49) == 0) begin
                boss_x = 10'($urandom_range(0, 1023));
                boss_y = 10'($urandom_range(0, 540));
            end
            if ($urandom_range(0, 49) == 0) maxh = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                b_en[i] = ($urandom_range(0, 3) == 0);
                x = int'(boss_x) + int'($urandom_range(0, 90)) - 20;
                y = int'(boss_y) + 480 + int'($urandom_range(0, 110)) - 50;
                if (x < 0) x = 0;
                if (x > 1023) x = 1023;
                if (y > 1023) y = 1023;
                set_bullet(i, x, y);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/boss_hit_judge_mc.md
BOSS_HIT_JUDGE_MC -- requirements
Module: boss_hit_judge_mc

Interface
REQ-001 Parameter NB, default 4: number of independent player-bullet channels, range 1..8.
REQ-002 Parameter HW, default 4: health counter width.
REQ-003 Parameter BOX_L/BOX_R/BOX_T/BOX_B, defaults 10/50/40/50: hitbox extents in pixels around the boss anchor.
REQ-004 Parameter Y_OFS, default 480: vertical offset added to boss_y to form the anchor Y.
REQ-005 Parameter DMG_MODE, default 0: 0 = at most 1 damage per cycle; 1 = damage equals the number of colliding channels.
REQ-006 Parameters INV_CYC/DEAD_CYC/REV_CYC, defaults 150000/67108864/375000: invulnerable, dead and revive durations in cycles, each at least 1.
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 rst  in  1  reset, synchronous, active-low.
REQ-009 boss_x, boss_y  in  10 each  boss position.
REQ-010 b_x, b_y  in  NB*10 each  packed bullet positions; channel i occupies bits [10i+9:10i].
REQ-011 b_en  in  NB  per-channel bullet-exists flag.
REQ-012 boss_en  in  1  boss present.
REQ-013 max_health  in  HW  health loaded at spawn and revive.
REQ-014 b_kill  out  NB  one-cycle pulse per channel: bullet consumed by a hit.
REQ-015 hit  out  1  one-cycle pulse: damage applied this cycle.
REQ-016 health  out  HW  current boss health.
REQ-017 boom  out  1  high throughout DEAD.
REQ-018 revive  out  1  high throughout REVIVE.
REQ-019 state  out  3  encoded FSM state: IDLE=0, ALIVE=1, INVULN=2, DEAD=3, REVIVE=4.

Function
REQ-020 boss_x and boss_y + Y_OFS shall be registered each cycle into an 11-bit anchor (ax, ay); all comparisons shall use the registered anchor and be evaluated at 11-bit or wider width, with no wrap-around.
REQ-021 Channel i collides when b_en[i], b_x_i >= ax-BOX_L, b_x_i < ax+BOX_R, b_y_i > ay-BOX_T and b_y_i < ay+BOX_B; ax-BOX_L below 0 clamps to 0.
REQ-022 Collisions shall be acted on only in ALIVE; in all other states b_kill and hit shall be 0.
REQ-023 In ALIVE, every colliding channel shall assert b_kill[i] for exactly one cycle, registered one cycle after detection.
REQ-024 Damage shall be 1 when DMG_MODE=0, or the popcount of collisions when DMG_MODE=1; health shall saturate at 0 and never underflow.
REQ-025 FSM IDLE: health=max_health; go to ALIVE when boss_en=1.
REQ-026 FSM ALIVE: on a hit leaving health>0, go to INVULN; on a hit leaving health=0, go to DEAD.
REQ-027 FSM INVULN: remain for INV_CYC cycles, then return to ALIVE.
REQ-028 FSM DEAD: boom=1; remain for DEAD_CYC cycles, then reload health=max_health and go to REVIVE.
REQ-029 FSM REVIVE: revive=1; remain for REV_CYC cycles, then go to ALIVE.
REQ-030 boss_en=0 in any state shall force IDLE on the next cycle, clear the timer and reload health; this takes priority over a simultaneous hit.
REQ-031 A single shared timer shall be zeroed on every state entry; the dwell time in each timed state shall be exactly its parameter value.
REQ-032 max_health=0 shall be treated as 1.
REQ-033 Multiple collisions in the same cycle shall produce one hit pulse and one FSM transition.

Reset
REQ-034 When rst=0 at a clock edge: state=IDLE, health=max_health, b_kill=0, hit=0, boom=0, revive=0, timer=0, anchor=0; asserting reset in any state shall abort that state.

Verification
REQ-035 NB=4, max_health=3, bullet on channel 2 inside box -> b_kill=0100 pulse, hit pulse, health=2, state=INVULN for INV_CYC cycles, then ALIVE.
REQ-036 DMG_MODE=1, channels 0, 1 and 3 collide in the same cycle with health=2 -> b_kill=1011, health=0, state=DEAD, boom=1.
REQ-037 Bullet at b_x=ax+BOX_R or b_y=ay-BOX_T -> no collision; b_x=ax-BOX_L -> collision.
REQ-038 boss_x=5 with BOX_L=10 -> lower X bound clamps to 0; bullet at b_x=0 collides.
REQ-039 Full sequence DEAD -> REVIVE -> ALIVE -> health=max_health; boom high exactly DEAD_CYC cycles; revive high exactly REV_CYC cycles.
REQ-040 boss_en dropped during INVULN with a simultaneous collision -> IDLE next cycle, no b_kill; rst=0 mid-DEAD -> boom=0 next cycle.
